// File: rtl/branch_predictor.sv
// Direct-mapped 16-entry branch target buffer with 2-bit saturating counters.
// Combinational lookup from fetch, update and mispredict detection at resolution in EX.
module branch_predictor (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IF_PC,
    output logic        PREDICT_TAKEN,
    output logic [31:0] PREDICT_TARGET,
    input  logic        EX_VALID,
    input  logic        EX_IS_BRANCH,
    input  logic [31:0] EX_PC,
    input  logic [31:0] EX_TARGET,
    input  logic        BRANCH_TAKEN,
    input  logic        EX_PRED_TAKEN,
    input  logic [31:0] EX_PRED_TARGET,
    output logic        FLUSH,
    output logic [31:0] REDIRECT_PC,
    output logic [31:0] BRANCH_COUNT,
    output logic [31:0] MISPREDICT_COUNT
);
    localparam int ENTRIES = 16;

    logic [ENTRIES-1:0]        valid;
    logic [ENTRIES-1:0][25:0]  tag;
    logic [ENTRIES-1:0][31:0]  target;
    logic [ENTRIES-1:0][1:0]   ctr;

    logic [3:0] if_idx, ex_idx;
    logic       if_hit, ex_hit, resolve, mispredict;

    assign if_idx = IF_PC[5:2];
    assign ex_idx = EX_PC[5:2];
    assign if_hit = valid[if_idx] && (tag[if_idx] == IF_PC[31:6]);
    assign ex_hit = valid[ex_idx] && (tag[ex_idx] == EX_PC[31:6]);

    // Lookup reads the registered table, so a same-entry update is seen next cycle.
    assign PREDICT_TAKEN  = RESET && if_hit && ctr[if_idx][1];
    assign PREDICT_TARGET = PREDICT_TAKEN ? target[if_idx] : IF_PC + 32'd4;

    assign resolve    = EX_VALID && EX_IS_BRANCH;
    assign mispredict = (BRANCH_TAKEN != EX_PRED_TAKEN) ||
                        (BRANCH_TAKEN && EX_PRED_TAKEN && (EX_TARGET != EX_PRED_TARGET));
    assign FLUSH       = RESET && resolve && mispredict;
    assign REDIRECT_PC = BRANCH_TAKEN ? EX_TARGET : EX_PC + 32'd4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid            <= '0;
            tag              <= '0;
            target           <= '0;
            ctr              <= {ENTRIES{2'b01}};
            BRANCH_COUNT     <= '0;
            MISPREDICT_COUNT <= '0;
        end else if (resolve) begin
            BRANCH_COUNT <= BRANCH_COUNT + 32'd1;
            if (mispredict)
                MISPREDICT_COUNT <= MISPREDICT_COUNT + 32'd1;
            if (ex_hit) begin
                if (BRANCH_TAKEN) begin
                    if (ctr[ex_idx] != 2'b11)
                        ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
                    target[ex_idx] <= EX_TARGET;
                end else if (ctr[ex_idx] != 2'b00) begin
                    ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
                end
            end else if (BRANCH_TAKEN) begin
                // Taken miss replaces whatever occupied the slot, starting weakly taken.
                valid[ex_idx]  <= 1'b1;
                tag[ex_idx]    <= EX_PC[31:6];
                target[ex_idx] <= EX_TARGET;
                ctr[ex_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, training, aliasing, gating, counters, reset.
module tb_branch_predictor;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IF_PC;
    logic        PREDICT_TAKEN;
    logic [31:0] PREDICT_TARGET;
    logic        EX_VALID, EX_IS_BRANCH, BRANCH_TAKEN, EX_PRED_TAKEN;
    logic [31:0] EX_PC, EX_TARGET, EX_PRED_TARGET;
    logic        FLUSH;
    logic [31:0] REDIRECT_PC, BRANCH_COUNT, MISPREDICT_COUNT;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor dut (
        .CLK(CLK), .RESET(RESET), .IF_PC(IF_PC),
        .PREDICT_TAKEN(PREDICT_TAKEN), .PREDICT_TARGET(PREDICT_TARGET),
        .EX_VALID(EX_VALID), .EX_IS_BRANCH(EX_IS_BRANCH), .EX_PC(EX_PC),
        .EX_TARGET(EX_TARGET), .BRANCH_TAKEN(BRANCH_TAKEN),
        .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_PRED_TARGET(EX_PRED_TARGET),
        .FLUSH(FLUSH), .REDIRECT_PC(REDIRECT_PC),
        .BRANCH_COUNT(BRANCH_COUNT), .MISPREDICT_COUNT(MISPREDICT_COUNT)
    );

    always #5 CLK = ~CLK;

    // Present a resolution on the EX inputs (stimulus only).
    task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
        EX_VALID = 1'b1; EX_IS_BRANCH = 1'b1; EX_PC = pc; BRANCH_TAKEN = tk;
        EX_TARGET = tgt; EX_PRED_TAKEN = ptk; EX_PRED_TARGET = ptgt;
        #1;
    endtask

    // Clock the pending resolution in, then retire it.
    task automatic go();
        @(posedge CLK);
        @(negedge CLK);
        EX_VALID = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        EX_VALID = 1'b0;
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
        @(negedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; IF_PC = 32'h100;
        drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        @(posedge CLK); #1;
        n_checks++; if (PREDICT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL rst_pt got %b exp 0", PREDICT_TAKEN); end
        n_checks++; if (PREDICT_TARGET !== 32'h104) begin n_fail++; $display("FAIL rst_ptgt got %h exp 00000104", PREDICT_TARGET); end
        n_checks++; if (FLUSH !== 1'b0) begin n_fail++; $display("FAIL rst_flush got %b exp 0", FLUSH); end
        n_checks++; if (BRANCH_COUNT !== 32'h0 || MISPREDICT_COUNT !== 32'h0) begin n_fail++;
            $display("FAIL rst_cnt got %h/%h exp 0/0", BRANCH_COUNT, MISPREDICT_COUNT); end
        @(negedge CLK);
        EX_VALID = 1'b0;
        RESET = 1'b1;
        #1;
        n_checks++; if (PREDICT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL rst_no_update got %b exp 0", PREDICT_TAKEN); end
    endtask

    task automatic test_cold_miss();
        IF_PC = 32'h100; #1;
        n_checks++; if (PREDICT_TAKEN !== 1'b0 || PREDICT_TARGET !== 32'h104) begin n_fail++;
            $display("FAIL cold_lookup got %b/%h exp 0/00000104", PREDICT_TAKEN, PREDICT_TARGET); end
        drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        n_checks++; if (FLUSH !== 1'b1 || REDIRECT_PC !== 32'h80) begin n_fail++;
            $display("FAIL cold_flush got %b/%h exp 1/00000080", FLUSH, REDIRECT_PC); end
        go();
        n_checks++; if (PREDICT_TAKEN !== 1'b1 || PREDICT_TARGET !== 32'h80) begin n_fail++;
            $display("FAIL cold_alloc got %b/%h exp 1/00000080", PREDICT_TAKEN, PREDICT_TARGET); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            drive(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            n_checks++; if (FLUSH !== 1'b0) begin n_fail++; $display("FAIL sat_correct_flush[%0d] got %b exp 0", i, FLUSH); end
            go();
        end
        drive(32'h100, 1'b0, 32'h80, 1'b1, 32'h80); go();
        n_checks++; if (PREDICT_TAKEN !== 1'b1) begin n_fail++; $display("FAIL hyst_nt1 got %b exp 1", PREDICT_TAKEN); end
        drive(32'h100, 1'b0, 32'h80, 1'b1, 32'h80); go();
        n_checks++; if (PREDICT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL hyst_nt2 got %b exp 0", PREDICT_TAKEN); end
        drive(32'h100, 1'b0, 32'h80, 1'b0, 32'h80); go();
        drive(32'h100, 1'b0, 32'h80, 1'b0, 32'h80); go();
        // Counter at 00 must stay there, so one taken only reaches 01 (not taken).
        drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h80); go();
        n_checks++; if (PREDICT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL sat_floor got %b exp 0", PREDICT_TAKEN); end
    endtask

    task automatic test_collision();
        IF_PC = 32'h100;
        drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        n_checks++; if (PREDICT_TAKEN !== 1'b0) begin n_fail++; $display("FAIL coll_same_cycle got %b exp 0", PREDICT_TAKEN); end
        go();
        n_checks++; if (PREDICT_TAKEN !== 1'b1 || PREDICT_TARGET !== 32'h80) begin n_fail++;
            $display("FAIL coll_next_cycle got %b/%h exp 1/00000080", PREDICT_TAKEN, PREDICT_TARGET); end
    endtask

    task automatic test_alias();
        drive(32'h140, 1'b1, 32'h200, 1'b0, 32'h0);
        n_checks++; if (FLUSH !== 1'b1 || REDIRECT_PC !== 32'h200) begin n_fail++;
            $display("FAIL alias_flush got %b/%h exp 1/00000200", FLUSH, REDIRECT_PC); end
        go();
        IF_PC = 32'h100; #1;
        n_checks++; if (PREDICT_TAKEN !== 1'b0 || PREDICT_TARGET !== 32'h104) begin n_fail++;
            $display("FAIL alias_evict got %b/%h exp 0/00000104", PREDICT_TAKEN, PREDICT_TARGET); end
        IF_PC = 32'h140; #1;
        n_checks++; if (PREDICT_TAKEN !== 1'b1 || PREDICT_TARGET !== 32'h200) begin n_fail++;
            $display("FAIL alias_new got %b/%h exp 1/00000200", PREDICT_TAKEN, PREDICT_TARGET); end
        drive(32'h140, 1'b1, 32'h200, 1'b1, 32'h204);
        n_checks++; if (FLUSH !== 1'b1 || REDIRECT_PC !== 32'h200) begin n_fail++;
            $display("FAIL tgt_mismatch got %b/%h exp 1/00000200", FLUSH, REDIRECT_PC); end
        go();
    endtask

    task automatic test_gating();
        do_reset();
        IF_PC = 32'h100;
        drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h0); go();
        drive(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        EX_VALID = 1'b0; #1;
        n_checks++; if (FLUSH !== 1'b0) begin n_fail++; $display("FAIL gate_valid_flush got %b exp 0", FLUSH); end
        @(posedge CLK); @(negedge CLK);
        EX_VALID = 1'b1; EX_IS_BRANCH = 1'b0; #1;
        n_checks++; if (FLUSH !== 1'b0) begin n_fail++; $display("FAIL gate_br_flush got %b exp 0", FLUSH); end
        @(posedge CLK); @(negedge CLK);
        EX_VALID = 1'b0; #1;
        n_checks++; if (PREDICT_TAKEN !== 1'b1 || PREDICT_TARGET !== 32'h80) begin n_fail++;
            $display("FAIL gate_table got %b/%h exp 1/00000080", PREDICT_TAKEN, PREDICT_TARGET); end
        n_checks++; if (BRANCH_COUNT !== 32'd1 || MISPREDICT_COUNT !== 32'd1) begin n_fail++;
            $display("FAIL gate_cnt got %0d/%0d exp 1/1", BRANCH_COUNT, MISPREDICT_COUNT); end
        drive(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        n_checks++; if (FLUSH !== 1'b1 || REDIRECT_PC !== 32'h104) begin n_fail++;
            $display("FAIL nt_mispredict got %b/%h exp 1/00000104", FLUSH, REDIRECT_PC); end
        go();
        n_checks++; if (PREDICT_TAKEN !== 1'b0 || BRANCH_COUNT !== 32'd2 || MISPREDICT_COUNT !== 32'd2) begin n_fail++;
            $display("FAIL nt_update got pt=%b cnt=%0d/%0d exp 0 2/2", PREDICT_TAKEN, BRANCH_COUNT, MISPREDICT_COUNT); end
    endtask

    task automatic test_counters();
        logic [9:0] mis_pat;
        int flushes;
        mis_pat = 10'b01_0010_1001;
        flushes = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(32'h400, 1'b0, 32'h0, mis_pat[i], 32'h0);
            if (FLUSH === 1'b1) flushes++;
            go();
        end
        n_checks++; if (BRANCH_COUNT !== 32'd10 || MISPREDICT_COUNT !== 32'd4) begin n_fail++;
            $display("FAIL cnt_ten got %0d/%0d exp 10/4", BRANCH_COUNT, MISPREDICT_COUNT); end
        n_checks++; if (flushes != 4) begin n_fail++; $display("FAIL cnt_flushes got %0d exp 4", flushes); end
    endtask

    task automatic test_wrap();
        force dut.BRANCH_COUNT = 32'hFFFF_FFFF;
        #1;
        release dut.BRANCH_COUNT;
        drive(32'h400, 1'b0, 32'h0, 1'b0, 32'h0); go();
        n_checks++; if (BRANCH_COUNT !== 32'h0 || MISPREDICT_COUNT !== 32'd4) begin n_fail++;
            $display("FAIL cnt_wrap got %h/%0d exp 00000000/4", BRANCH_COUNT, MISPREDICT_COUNT); end
    endtask

    task automatic test_async_reset();
        IF_PC = 32'h100;
        drive(32'h100, 1'b1, 32'h80, 1'b0, 32'h0); go();
        n_checks++; if (PREDICT_TAKEN !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b exp 1", PREDICT_TAKEN); end
        #2;
        RESET = 1'b0;
        #1;
        n_checks++; if (BRANCH_COUNT !== 32'h0 || MISPREDICT_COUNT !== 32'h0) begin n_fail++;
            $display("FAIL areset_cnt got %h/%h exp 0/0", BRANCH_COUNT, MISPREDICT_COUNT); end
        n_checks++; if (PREDICT_TAKEN !== 1'b0 || PREDICT_TARGET !== 32'h104) begin n_fail++;
            $display("FAIL areset_pt got %b/%h exp 0/00000104", PREDICT_TAKEN, PREDICT_TARGET); end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
    endtask

    initial begin
        EX_VALID = 1'b0; EX_IS_BRANCH = 1'b0; EX_PC = '0; EX_TARGET = '0;
        BRANCH_TAKEN = 1'b0; EX_PRED_TAKEN = 1'b0; EX_PRED_TARGET = '0;
        RESET = 1'b0; IF_PC = '0;
        @(negedge CLK);
        test_reset();
        test_cold_miss();
        test_saturation();
        test_collision();
        test_alias();
        test_gating();
        test_counters();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL provide the following ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- IF_PC  input  32  PC of the instruction in fetch.
- PREDICT_TAKEN  output  1  fetch must steer to PREDICT_TARGET.
- PREDICT_TARGET  output  32  predicted branch target.
- EX_VALID  input  1  the EX stage holds a live instruction (not a bubble, not stalled).
- EX_IS_BRANCH  input  1  the EX instruction is a conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU).
- EX_PC  input  32  PC of the EX instruction.
- EX_TARGET  input  32  computed branch target (EX_PC + B-immediate).
- BRANCH_TAKEN  input  1  resolved outcome from the EX-stage branch comparator.
- EX_PRED_TAKEN  input  1  prediction made for this instruction, carried down the pipeline registers.
- EX_PRED_TARGET  input  32  predicted target made for this instruction, carried down the pipeline registers.
- FLUSH  output  1  mispredict: squash the IF and ID stages.
- REDIRECT_PC  output  32  correct next PC, valid while FLUSH = 1.
- BRANCH_COUNT  output  32  number of resolved branches.
- MISPREDICT_COUNT  output  32  number of mispredicts.

Function
REQ-003 The storage SHALL be a 16-entry direct-mapped table, indexed by PC[5:2]. Each entry holds VALID (1 bit), TAG = PC[31:6] (26 bits), TARGET (32 bits) and CTR (2-bit saturating counter).
REQ-004 Lookup SHALL be combinational from IF_PC. HIT = VALID && (TAG == IF_PC[31:6]).
- PREDICT_TAKEN = HIT && CTR[1].
- PREDICT_TARGET = entry TARGET when PREDICT_TAKEN = 1, else IF_PC + 4.
REQ-005 A resolution event is defined as EX_VALID && EX_IS_BRANCH. No table, counter or output change SHALL occur outside a resolution event.
REQ-006 MISPREDICT SHALL equal (BRANCH_TAKEN != EX_PRED_TAKEN) || (BRANCH_TAKEN && EX_PRED_TAKEN && EX_TARGET != EX_PRED_TARGET).
REQ-007 FLUSH SHALL be combinational: it equals resolution event && MISPREDICT, in the same cycle as the event.
REQ-008 REDIRECT_PC SHALL be BRANCH_TAKEN ? EX_TARGET : EX_PC + 4, with 32-bit wrap on the addition. It is don't-care while FLUSH = 0.
REQ-009 On a resolution event, the table SHALL update at the rising CLK edge, at the entry indexed by EX_PC[5:2]:
- Hit, taken: CTR increments, saturating at 2'b11; TARGET <= EX_TARGET.
- Hit, not taken: CTR decrements, saturating at 2'b00; TARGET unchanged.
- Miss, taken: allocate by overwriting the entry. VALID <= 1, TAG <= EX_PC[31:6], TARGET <= EX_TARGET, CTR <= 2'b10.
- Miss, not taken: no change to the entry.
REQ-010 If the IF lookup and the EX update address the same entry in the same cycle, the lookup SHALL return the pre-update contents. There is no bypass.
REQ-011 On each resolution event, BRANCH_COUNT SHALL increment by 1 at the clock edge. MISPREDICT_COUNT SHALL increment by 1 when MISPREDICT = 1. Both counters wrap from 0xFFFFFFFF to 0.
REQ-012 EX_PC and EX_TARGET bits [1:0] SHALL be ignored for indexing; targets are stored unmodified.

Reset
REQ-013 While RESET = 0, asynchronously and independent of CLK:
- all VALID = 0 and all CTR = 2'b01;
- BRANCH_COUNT = 0 and MISPREDICT_COUNT = 0;
- PREDICT_TAKEN = 0 and PREDICT_TARGET = IF_PC + 4.
REQ-014 While RESET = 0, FLUSH SHALL be forced to 0. A resolution event coincident with reset assertion SHALL leave no state change.
REQ-015 After RESET deasserts, the first update SHALL occur at the first rising edge on which a resolution event is present.

Verification
REQ-016 Cold miss. After reset, IF_PC=0x00000100 -> PREDICT_TAKEN=0, PREDICT_TARGET=0x00000104. Then resolve EX_PC=0x100, taken, EX_TARGET=0x80, EX_PRED_TAKEN=0 -> in the same cycle FLUSH=1, REDIRECT_PC=0x80. Next cycle, IF_PC=0x100 -> PREDICT_TAKEN=1, PREDICT_TARGET=0x80.
REQ-017 Saturation and hysteresis. Resolve EX_PC=0x100 as taken three more times -> CTR=2'b11. Then not-taken once -> PREDICT_TAKEN still 1. Not-taken twice more -> PREDICT_TAKEN=0 (CTR=2'b00). A further not-taken holds CTR at 2'b00.
REQ-018 Alias and target mismatch.
- Resolve EX_PC=0x140 (same index as 0x100, different tag), taken, EX_TARGET=0x200, with prediction not taken -> the entry is replaced; IF_PC=0x100 now misses.
- Resolve taken with EX_PRED_TAKEN=1 and EX_PRED_TARGET=0x204 against EX_TARGET=0x200 -> FLUSH=1, REDIRECT_PC=0x200.
REQ-019 Not-taken mispredict and gating.
- Predicted taken, BRANCH_TAKEN=0, EX_PC=0x100 -> FLUSH=1, REDIRECT_PC=0x104.
- The same inputs with EX_VALID=0, and separately with EX_IS_BRANCH=0 -> FLUSH=0, and the table and both counters are unchanged.
REQ-020 Counters and reset.
- Ten resolutions with four mispredicts -> BRANCH_COUNT=10, MISPREDICT_COUNT=4.
- Preload BRANCH_COUNT to 0xFFFFFFFF, then resolve once -> BRANCH_COUNT=0.
- Assert RESET mid-cycle, with no CLK edge -> all counters immediately 0; IF_PC=0x100 immediately gives PREDICT_TAKEN=0.
REQ-021 Same-entry collision. In one cycle, present IF_PC=0x100 alongside a taken resolution of EX_PC=0x100 on an entry with CTR=2'b01 -> that cycle PREDICT_TAKEN=0; the following cycle PREDICT_TAKEN=1.
